// File: rtl/mem_pkg.sv
// Shared types and sizing for the memory responder block.
// Latency: none, declarations only.
// Backpressure: not applicable.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

package mem_pkg;

    // Kept aligned with the `WIDTH / `ADDR_WIDTH defines used by the bench side.
    localparam int WIDTH      = `WIDTH;
    localparam int ADDR_WIDTH = `ADDR_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Request as captured on the accept edge; held until completion.
    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between an initiator and the memory responder.
// Latency: none, wiring only.
// Backpressure: initiator holds off new requests until the ready_o pulse.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int WIDTH      = mem_pkg::WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
) ();

    logic                  valid_i;
    logic                  wr_rd_i;
    logic [WIDTH-1:0]      wdata_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      rdata_o;
    logic                  ready_o;

    modport master (
        output valid_i, wr_rd_i, wdata_i, addr_i,
        input  rdata_o, ready_o
    );

    modport slave (
        input  valid_i, wr_rd_i, wdata_i, addr_i,
        output rdata_o, ready_o
    );

endinterface

// File: rtl/mem_array.sv
// DEPTH x WIDTH storage, one write port and one registered read port, async clear.
// Latency: write lands on the edge; read data appears on the edge it is requested.
// Backpressure: none, every enabled access completes on its edge.
module mem_array
    import mem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Next storage contents and read register; read data holds when not reading.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Storage and read register, cleared as a whole by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed per-direction latency, one-cycle ready_o.
// Latency: ready_o high in the cycle after accept edge + WR_LATENCY / RD_LATENCY.
// Backpressure: requests are only taken in IDLE; inputs are ignored while a request is in flight.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH      = mem_pkg::WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_responder_if.slave  bus
);

    localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (WR_LATENCY < 1 || RD_LATENCY < 1) begin : g_bad_latency
        $fatal(1, "mem_responder: WR_LATENCY and RD_LATENCY must both be >= 1");
    end

    // The captured request struct is sized from the package; the two must agree.
    if (WIDTH != mem_pkg::WIDTH || ADDR_WIDTH != mem_pkg::ADDR_WIDTH) begin : g_bad_width
        $fatal(1, "mem_responder: WIDTH/ADDR_WIDTH must match mem_pkg");
    end

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    mem_req_t         req_q,   req_d;
    logic             ready_q, ready_d;

    logic             mem_we;
    logic             mem_re;
    logic [WIDTH-1:0] arr_rdata;

    // Next-state, counter, capture and completion strobes. RESP is the cycle
    // before the pulse: leaving it performs the access and raises ready_o.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    req_d.wr_rd = bus.wr_rd_i;
                    req_d.addr  = bus.addr_i;
                    req_d.wdata = bus.wdata_i;
                    if (bus.wr_rd_i) begin
                        cnt_d   = WR_CNT;
                        state_d = (WR_LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        cnt_d   = RD_CNT;
                        state_d = (RD_LATENCY == 1) ? RESP : WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                mem_we  = req_q.wr_rd;
                mem_re  = !req_q.wr_rd;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counter, captured request and ready pulse registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
        end
    end

    mem_array u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .waddr_i (req_q.addr),
        .wdata_i (req_q.wdata),
        .re_i    (mem_re),
        .raddr_i (req_q.addr),
        .rdata_o (arr_rdata)
    );

    assign bus.ready_o = ready_q;
    assign bus.rdata_o = arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: default-latency instance checked every cycle against a
// request-level model, plus a slower-latency instance checked by measured latency.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    mem_responder_if #(.WIDTH(16), .ADDR_WIDTH(4)) bus_a ();
    mem_responder_if #(.WIDTH(16), .ADDR_WIDTH(4)) bus_b ();

    mem_responder #(.WIDTH(16), .ADDR_WIDTH(4), .WR_LATENCY(1), .RD_LATENCY(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a)
    );

    mem_responder #(.WIDTH(16), .ADDR_WIDTH(4), .WR_LATENCY(3), .RD_LATENCY(4)) dut_l (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b)
    );

    // ---------------- request-level model of the default instance ----------------
    logic [15:0] m_mem [16];
    bit          m_busy    = 1'b0;
    int          m_left    = 0;
    logic        m_wr      = 1'b0;
    logic [3:0]  m_addr    = '0;
    logic [15:0] m_data    = '0;
    bit          exp_ready = 1'b0;
    logic [15:0] exp_rdata = '0;

    // A request taken at edge E0 completes at edge E0+L: writes land in storage,
    // reads copy storage into the expected read data, and ready is high for the
    // following cycle. No new request is taken on a completion edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) m_mem[i] = '0;
                m_busy    = 1'b0;
                m_left    = 0;
                exp_ready = 1'b0;
                exp_rdata = '0;
            end else begin
                exp_ready = 1'b0;
                if (m_busy) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy    = 1'b0;
                        exp_ready = 1'b1;
                        if (m_wr) m_mem[m_addr] = m_data;
                        else      exp_rdata = m_mem[m_addr];
                    end
                end else if (bus_a.valid_i) begin
                    m_busy = 1'b1;
                    m_wr   = bus_a.wr_rd_i;
                    m_addr = bus_a.addr_i;
                    m_data = bus_a.wdata_i;
                    m_left = bus_a.wr_rd_i ? 1 : 2;
                end
            end
        end
    end

    // Per-cycle comparison of the default instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                checks++;
                if (bus_a.ready_o !== exp_ready) begin
                    errors++;
                    $display("FAIL cycle_ready @%0t: got %b expected %b", $time, bus_a.ready_o, exp_ready);
                end
                checks++;
                if (bus_a.rdata_o !== exp_rdata) begin
                    errors++;
                    $display("FAIL cycle_rdata @%0t: got 0x%04h expected 0x%04h", $time, bus_a.rdata_o, exp_rdata);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic wr,
                         input logic [3:0] a, input logic [15:0] d);
        if (sel) begin
            bus_b.valid_i = v; bus_b.wr_rd_i = wr; bus_b.addr_i = a; bus_b.wdata_i = d;
        end else begin
            bus_a.valid_i = v; bus_a.wr_rd_i = wr; bus_a.addr_i = a; bus_a.wdata_i = d;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? bus_b.ready_o : bus_a.ready_o;
    endfunction

    function automatic logic [15:0] get_rdata(input bit sel);
        return sel ? bus_b.rdata_o : bus_a.rdata_o;
    endfunction

    // Called at a negedge with the responder idle. Issues one request, returns the
    // number of edges from accept to the ready pulse and the read data seen with
    // it, checks the pulse is one cycle wide, and returns at the negedge after it.
    task automatic txn(input bit sel, input logic wr, input logic [3:0] a,
                       input logic [15:0] d, input bit scramble,
                       output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 'x;
        drive(sel, 1'b1, wr, a, d);
        @(posedge clk);
        @(negedge clk);
        if (scramble) drive(sel, 1'b0, ~wr, 4'd8, ~d);
        else          drive(sel, 1'b0, wr, a, d);
        for (int k = 0; k <= 20; k++) begin
            if (get_ready(sel)) begin
                lat = k;
                rd  = get_rdata(sel);
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL txn_timeout: no ready_o within 20 cycles (sel=%0d addr=%0d)", sel, a);
        end else begin
            @(negedge clk);
            chk("pulse_width", {31'd0, get_ready(sel)}, 32'd0);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int          lat;
        logic [15:0] rd;
        int          pulses;

        drive(1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_ready_a", {31'd0, bus_a.ready_o}, 32'd0);
        chk("reset_rdata_a", {16'd0, bus_a.rdata_o}, 32'd0);
        chk("reset_ready_b", {31'd0, bus_b.ready_o}, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Write then read
        txn(1'b0, 1'b1, 4'd3, 16'hA5A5, 1'b0, lat, rd);
        chk("wr_latency", lat, 32'd1);
        txn(1'b0, 1'b0, 4'd3, 16'h0000, 1'b0, lat, rd);
        chk("rd_latency", lat, 32'd2);
        chk("rd_addr3", {16'd0, rd}, 32'h0000_A5A5);
        chk("model_rdata_addr3", {16'd0, exp_rdata}, 32'h0000_A5A5);

        // Back-to-back writes including the top address
        txn(1'b0, 1'b1, 4'd0,  16'h1111, 1'b0, lat, rd);
        chk("b2b_wr0_latency", lat, 32'd1);
        txn(1'b0, 1'b1, 4'd15, 16'h2222, 1'b0, lat, rd);
        chk("b2b_wr15_latency", lat, 32'd1);
        txn(1'b0, 1'b1, 4'd0,  16'h3333, 1'b0, lat, rd);
        txn(1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, lat, rd);
        chk("b2b_rd0", {16'd0, rd}, 32'h0000_3333);
        txn(1'b0, 1'b0, 4'd15, 16'h0000, 1'b0, lat, rd);
        chk("b2b_rd15", {16'd0, rd}, 32'h0000_2222);
        chk("model_mem15", {16'd0, m_mem[15]}, 32'h0000_2222);

        // Inputs changed and valid dropped while the read is in flight
        txn(1'b0, 1'b1, 4'd7, 16'h0BEE, 1'b0, lat, rd);
        txn(1'b0, 1'b0, 4'd7, 16'h0000, 1'b1, lat, rd);
        chk("midchg_latency", lat, 32'd2);
        chk("midchg_rdata", {16'd0, rd}, 32'h0000_0BEE);
        txn(1'b0, 1'b0, 4'd8, 16'h0000, 1'b0, lat, rd);
        chk("midchg_addr8_untouched", {16'd0, rd}, 32'h0000_0000);

        // rdata_o holds across a write
        txn(1'b0, 1'b1, 4'd2, 16'h00FF, 1'b0, lat, rd);
        txn(1'b0, 1'b0, 4'd2, 16'h0000, 1'b0, lat, rd);
        chk("hold_first_read", {16'd0, rd}, 32'h0000_00FF);
        txn(1'b0, 1'b1, 4'd2, 16'hFF00, 1'b0, lat, rd);
        chk("hold_after_write_pulse", {16'd0, rd}, 32'h0000_00FF);
        repeat (3) @(negedge clk);
        chk("hold_idle", {16'd0, bus_a.rdata_o}, 32'h0000_00FF);
        txn(1'b0, 1'b0, 4'd2, 16'h0000, 1'b0, lat, rd);
        chk("hold_next_read", {16'd0, rd}, 32'h0000_FF00);

        // Reset while a read is pending
        drive(1'b0, 1'b1, 1'b0, 4'd3, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, bus_a.ready_o}, 32'd0);
        chk("midrst_rdata", {16'd0, bus_a.rdata_o}, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus_a.ready_o) pulses++;
        end
        chk("midrst_no_pulse", pulses, 32'd0);
        txn(1'b0, 1'b0, 4'd5, 16'h0000, 1'b0, lat, rd);
        chk("postrst_rd5", {16'd0, rd}, 32'h0000_0000);
        txn(1'b0, 1'b0, 4'd3, 16'h0000, 1'b0, lat, rd);
        chk("postrst_rd3_cleared", {16'd0, rd}, 32'h0000_0000);

        // Longer latencies on the second instance
        txn(1'b1, 1'b1, 4'd1, 16'h1234, 1'b0, lat, rd);
        chk("lat_wr3", lat, 32'd3);
        txn(1'b1, 1'b0, 4'd1, 16'h0000, 1'b0, lat, rd);
        chk("lat_rd4", lat, 32'd4);
        chk("lat_rd4_data", {16'd0, rd}, 32'h0000_1234);
        txn(1'b1, 1'b1, 4'd15, 16'hBEEF, 1'b0, lat, rd);
        txn(1'b1, 1'b0, 4'd15, 16'h0000, 1'b1, lat, rd);
        chk("lat_rd4_scrambled", lat, 32'd4);
        chk("lat_rd4_scrambled_data", {16'd0, rd}, 32'h0000_BEEF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
